// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared types, address map and BCD step helper for the RTC bus responder
package rtc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        READ    = 2'd3
    } state_t;

    localparam logic [7:0] REG_SEC    = 8'h21;
    localparam logic [7:0] REG_MIN    = 8'h22;
    localparam logic [7:0] REG_HR     = 8'h23;
    localparam logic [7:0] REG_LIMIT  = 8'h40;
    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_HR = 8'h23;

    // Returns {carry, next}. Anything at/over the limit or with a bad low digit wraps to 0x00.
    function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] lim);
        logic [8:0] res;
        logic [3:0] hi_next;
        hi_next = v[7:4] + 4'd1;
        if (v >= lim || v[3:0] > 4'd9) begin
            res = {1'b1, 8'h00};
        end else if (v[3:0] == 4'd9) begin
            res = {1'b0, hi_next, 4'h0};
        end else begin
            res = {1'b0, v + 8'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - BCD sec/min/hr counter; host load overrides and drops a coincident tick
module bcd_time_counter
    import rtc_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       load_sec,
    input  logic       load_min,
    input  logic       load_hr,
    input  logic [7:0] load_data,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hr
);

    logic [8:0] sec_step;
    logic [8:0] min_step;
    logic [8:0] hr_step;

    always_comb begin
        sec_step = bcd_step(sec, BCD_MAX_MS);
        min_step = bcd_step(min, BCD_MAX_MS);
        hr_step  = bcd_step(hr, BCD_MAX_HR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sec <= 8'h00;
            min <= 8'h00;
            hr  <= 8'h00;
        end else if (load_sec || load_min || load_hr) begin
            if (load_sec) sec <= load_data;
            if (load_min) min <= load_data;
            if (load_hr)  hr  <= load_data;
        end else if (tick) begin
            sec <= sec_step[7:0];
            if (sec_step[8]) begin
                min <= min_step[7:0];
                if (min_step[8]) hr <= hr_step[7:0];
            end
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// rtl/rtc_bus_responder.sv - chip-side responder for the multiplexed 8-bit RTC address/data bus
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              ad,
    input  logic              tick_1hz,
    inout  wire  [7:0]        dato,
    output logic [ADDR_W-1:0] addr_latch,
    output logic              bus_drive,
    output logic [7:0]        time_sec,
    output logic [7:0]        time_min,
    output logic [7:0]        time_hr
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] SYNC_IDLE = 4'b1110;

    logic [3:0] sync_meta;
    logic [3:0] sync_q;
    logic [7:0] dato_q;
    logic       cs_s, rd_s, wr_s, ad_s;
    state_t     state, next_state;
    logic       commit_addr, commit_data, wr_release;
    logic       in_range, is_time, reg_we;
    logic [7:0] rd_data;
    logic [7:0] regs [DEPTH];

    assign {cs_s, rd_s, wr_s, ad_s} = sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_meta <= SYNC_IDLE;
            sync_q    <= SYNC_IDLE;
            dato_q    <= 8'h00;
        end else begin
            sync_meta <= {cs_n, rd_n, wr_n, ad};
            sync_q    <= sync_meta;
            dato_q    <= dato;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // rd and wr low together never enters a state and forces an active one back to IDLE
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!cs_s && !wr_s && rd_s)             next_state = ad_s ? WR_DATA : WR_ADDR;
                else if (!cs_s && !rd_s && wr_s && ad_s) next_state = READ;
            end
            WR_ADDR, WR_DATA: if (cs_s || wr_s || !rd_s) next_state = IDLE;
            READ:             if (cs_s || rd_s || !wr_s) next_state = IDLE;
            default:          next_state = IDLE;
        endcase
    end

    always_comb begin
        wr_release  = wr_s && rd_s;
        bus_drive   = (state == READ);
        commit_addr = (state == WR_ADDR) && wr_release;
        commit_data = (state == WR_DATA) && wr_release && in_range;
    end

    assign in_range = addr_latch < ADDR_W'(REG_LIMIT);
    assign is_time  = (addr_latch == ADDR_W'(REG_SEC)) || (addr_latch == ADDR_W'(REG_MIN)) ||
                      (addr_latch == ADDR_W'(REG_HR));
    assign reg_we   = commit_data && !is_time;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_latch <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            if (commit_addr) addr_latch <= dato_q[ADDR_W-1:0];
            if (reg_we)      regs[addr_latch[IDX_W-1:0]] <= dato_q;
        end
    end

    // Time registers live in the counter; the file entries at those addresses are never used
    bcd_time_counter u_time (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick_1hz),
        .load_sec  (commit_data && addr_latch == ADDR_W'(REG_SEC)),
        .load_min  (commit_data && addr_latch == ADDR_W'(REG_MIN)),
        .load_hr   (commit_data && addr_latch == ADDR_W'(REG_HR)),
        .load_data (dato_q),
        .sec       (time_sec),
        .min       (time_min),
        .hr        (time_hr)
    );

    always_comb begin
        rd_data = 8'h00;
        if (in_range) begin
            if (addr_latch == ADDR_W'(REG_SEC))      rd_data = time_sec;
            else if (addr_latch == ADDR_W'(REG_MIN)) rd_data = time_min;
            else if (addr_latch == ADDR_W'(REG_HR))  rd_data = time_hr;
            else                                     rd_data = regs[addr_latch[IDX_W-1:0]];
        end
    end

    assign dato = bus_drive ? rd_data : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb/tb_rtc_bus_responder.sv - self-checking bench for rtc_bus_responder against a byte-level model
module tb_rtc_bus_responder;

    logic       clk = 1'b0;
    logic       reset_n, cs_n, rd_n, wr_n, ad, tick_1hz;
    logic [7:0] host_dato;
    logic       host_drive;
    wire  [7:0] dato;
    logic [7:0] addr_latch, time_sec, time_min, time_hr;
    logic       bus_drive;

    int checks   = 0;
    int failures = 0;
    int model_reg [64];
    int model_addr;

    always #5 clk = ~clk;

    assign dato = host_drive ? host_dato : 8'hzz;

    rtc_bus_responder #(.ADDR_W(8), .DEPTH(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .ad         (ad),
        .tick_1hz   (tick_1hz),
        .dato       (dato),
        .addr_latch (addr_latch),
        .bus_drive  (bus_drive),
        .time_sec   (time_sec),
        .time_min   (time_min),
        .time_hr    (time_hr)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int bump(input int v, input int lim, output bit carry);
        int hi, lo, n;
        hi = v / 16;
        lo = v % 16;
        if (hi <= 9 && lo <= 9 && hi * 10 + lo < lim) begin
            n = hi * 10 + lo + 1;
            carry = 1'b0;
            return (n / 10) * 16 + (n % 10);
        end
        carry = 1'b1;
        return 0;
    endfunction

    task automatic model_tick();
        bit c;
        model_reg[33] = bump(model_reg[33], 59, c);
        if (c) begin
            model_reg[34] = bump(model_reg[34], 59, c);
            if (c) model_reg[35] = bump(model_reg[35], 23, c);
        end
    endtask

    function automatic logic [23:0] model_time();
        return {8'(model_reg[33]), 8'(model_reg[34]), 8'(model_reg[35])};
    endfunction

    function automatic logic [7:0] model_read();
        return (model_addr >= 64) ? 8'h00 : 8'(model_reg[model_addr]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_reg[i] = 0;
        model_addr = 0;
    endtask

    task automatic bus_write(input logic phase, input logic [7:0] v, input bit tick_at_commit);
        bit time_commit;
        host_dato = v; host_drive = 1'b1; ad = phase; cs_n = 1'b0; wr_n = 1'b0;
        step(4);
        wr_n = 1'b1; cs_n = 1'b1;
        step(2);
        if (tick_at_commit) tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0; host_drive = 1'b0; ad = 1'b0;
        step(1);
        time_commit = phase && model_addr >= 33 && model_addr <= 35;
        if (!phase) model_addr = int'(v);
        else if (model_addr < 64) model_reg[model_addr] = int'(v);
        if (tick_at_commit && !time_commit) model_tick();
    endtask

    task automatic bus_read(output logic [7:0] data, output logic [3:0] drv);
        host_drive = 1'b0; ad = 1'b1; cs_n = 1'b0; rd_n = 1'b0;
        step(2); drv[0] = bus_drive;
        step(1); drv[1] = bus_drive; data = dato;
        step(1); rd_n = 1'b1; cs_n = 1'b1;
        step(2); drv[2] = bus_drive;
        step(1); drv[3] = bus_drive;
        ad = 1'b0;
        step(1);
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        model_tick();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [3:0] drv;
        reset_n = 1'b0;
        step(3);
        checks++;
        if (bus_drive !== 1'b0) begin failures++; $display("FAIL reset_bus_drive got=%b exp=0", bus_drive); end
        checks++;
        if (addr_latch !== 8'h00) begin failures++; $display("FAIL reset_addr_latch got=%h exp=00", addr_latch); end
        checks++;
        if ({time_sec, time_min, time_hr} !== 24'h0) begin
            failures++; $display("FAIL reset_time got=%h exp=000000", {time_sec, time_min, time_hr});
        end
        reset_n = 1'b1;
        step(1);
        model_clear();
        bus_write(1'b0, 8'h05, 1'b0);
        bus_read(d, drv);
        checks++;
        if (d !== model_read()) begin failures++; $display("FAIL reset_read05 got=%h exp=%h", d, model_read()); end
        checks++;
        if (drv !== 4'b0110) begin failures++; $display("FAIL read_drive_timing got=%b exp=0110", drv); end
    endtask

    task automatic test_write_read();
        logic [7:0] d;
        logic [3:0] drv;
        bus_write(1'b0, 8'h10, 1'b0);
        bus_write(1'b1, 8'hA5, 1'b0);
        bus_read(d, drv);
        checks++;
        if (d !== 8'hA5 || d !== model_read()) begin failures++; $display("FAIL write_read got=%h exp=a5", d); end
        checks++;
        if (drv !== 4'b0110) begin failures++; $display("FAIL write_read_drive got=%b exp=0110", drv); end
        checks++;
        if (addr_latch !== 8'h10) begin failures++; $display("FAIL addr_latch got=%h exp=10", addr_latch); end
    endtask

    task automatic test_bcd_wrap();
        logic [7:0] vals [3] = '{8'h59, 8'h59, 8'h23};
        for (int i = 0; i < 3; i++) begin
            bus_write(1'b0, 8'h21 + 8'(i), 1'b0);
            bus_write(1'b1, vals[i], 1'b0);
        end
        pulse_tick();
        checks++;
        if ({time_sec, time_min, time_hr} !== 24'h000000 || model_time() !== 24'h000000) begin
            failures++; $display("FAIL full_wrap got=%h exp=000000", {time_sec, time_min, time_hr});
        end
        bus_write(1'b0, 8'h21, 1'b0);
        bus_write(1'b1, 8'h09, 1'b0);
        pulse_tick();
        checks++;
        if ({time_sec, time_min, time_hr} !== model_time()) begin
            failures++; $display("FAIL digit_carry got=%h exp=%h", {time_sec, time_min, time_hr}, model_time());
        end
        bus_write(1'b0, 8'h22, 1'b0);
        bus_write(1'b1, 8'h05, 1'b0);
        bus_write(1'b0, 8'h21, 1'b0);
        bus_write(1'b1, 8'h7A, 1'b0);
        pulse_tick();
        checks++;
        if ({time_sec, time_min} !== 16'h0006) begin
            failures++; $display("FAIL non_bcd_sec got=%h exp=0006", {time_sec, time_min});
        end
    endtask

    task automatic test_tick_collision();
        logic [7:0] d;
        logic [3:0] drv;
        bus_write(1'b0, 8'h21, 1'b0);
        bus_write(1'b1, 8'h30, 1'b1);
        checks++;
        if (time_sec !== 8'h30) begin failures++; $display("FAIL collision_time_wins got=%h exp=30", time_sec); end
        bus_write(1'b0, 8'h10, 1'b0);
        bus_write(1'b1, 8'h3C, 1'b1);
        checks++;
        if ({time_sec, time_min, time_hr} !== model_time()) begin
            failures++; $display("FAIL collision_other_addr got=%h exp=%h", {time_sec, time_min, time_hr}, model_time());
        end
        bus_read(d, drv);
        checks++;
        if (d !== 8'h3C) begin failures++; $display("FAIL collision_other_data got=%h exp=3c", d); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] d;
        logic [3:0] drv;
        int bad;
        bus_write(1'b0, 8'h45, 1'b0);
        bus_write(1'b1, 8'h77, 1'b0);
        bus_read(d, drv);
        checks++;
        if (d !== 8'h00 || drv !== 4'b0110) begin
            failures++; $display("FAIL oor_read got=%h/%b exp=00/0110", d, drv);
        end
        bad = 0;
        for (int a = 0; a < 64; a++) begin
            bus_write(1'b0, 8'(a), 1'b0);
            bus_read(d, drv);
            if (d !== model_read()) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL oor_regfile_scan got=%0d_bad exp=0_bad", bad); end
    endtask

    task automatic test_illegal();
        logic [7:0] d;
        logic [3:0] drv;
        int driven;
        bus_write(1'b0, 8'h10, 1'b0);
        for (int p = 0; p < 2; p++) begin
            driven = 0;
            host_dato = 8'hEE; host_drive = 1'b1; ad = p[0]; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
            for (int c = 0; c < 6; c++) begin step(1); if (bus_drive !== 1'b0) driven++; end
            rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
            for (int c = 0; c < 4; c++) begin step(1); if (bus_drive !== 1'b0) driven++; end
            host_drive = 1'b0; ad = 1'b0;
            checks++;
            if (driven != 0) begin failures++; $display("FAIL illegal_drive ad=%0d got=%0d exp=0", p, driven); end
            checks++;
            if (addr_latch !== 8'(model_addr)) begin
                failures++; $display("FAIL illegal_addr ad=%0d got=%h exp=%h", p, addr_latch, 8'(model_addr));
            end
        end
        bus_read(d, drv);
        checks++;
        if (d !== model_read()) begin failures++; $display("FAIL illegal_data got=%h exp=%h", d, model_read()); end
        driven = 0;
        host_drive = 1'b0; ad = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
        for (int c = 0; c < 6; c++) begin step(1); if (bus_drive !== 1'b0) driven++; end
        rd_n = 1'b1; cs_n = 1'b1;
        step(4);
        checks++;
        if (driven != 0) begin failures++; $display("FAIL read_ad0_drive got=%0d exp=0", driven); end
    endtask

    task automatic test_random();
        logic [7:0] d, v;
        logic [3:0] drv;
        bit t;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    if ($urandom_range(0, 2) == 0) v = 8'h20 + 8'($urandom_range(0, 4));
                    else v = 8'($urandom_range(0, 127));
                    bus_write(1'b0, v, 1'b0);
                end
                1: begin
                    v = 8'($urandom_range(0, 255));
                    t = ($urandom_range(0, 3) == 0);
                    bus_write(1'b1, v, t);
                end
                2: begin
                    bus_read(d, drv);
                    checks++;
                    if (d !== model_read() || drv !== 4'b0110) begin
                        failures++;
                        $display("FAIL rand_read it=%0d got=%h/%b exp=%h/0110", it, d, drv, model_read());
                    end
                end
                default: pulse_tick();
            endcase
            checks++;
            if ({time_sec, time_min, time_hr} !== model_time()) begin
                failures++; $display("FAIL rand_time it=%0d got=%h exp=%h", it, {time_sec, time_min, time_hr}, model_time());
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        logic [3:0] drv;
        bus_write(1'b0, 8'h21, 1'b0);
        bus_write(1'b1, 8'h42, 1'b0);
        host_drive = 1'b0; ad = 1'b1; cs_n = 1'b0; rd_n = 1'b0;
        step(3);
        checks++;
        if (bus_drive !== 1'b1) begin failures++; $display("FAIL midread_active got=%b exp=1", bus_drive); end
        reset_n = 1'b0;
        step(1);
        checks++;
        if (bus_drive !== 1'b0 || addr_latch !== 8'h00) begin
            failures++; $display("FAIL midread_reset got=%b/%h exp=0/00", bus_drive, addr_latch);
        end
        rd_n = 1'b1; cs_n = 1'b1; ad = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(3);
        model_clear();
        checks++;
        if ({time_sec, time_min, time_hr} !== 24'h0) begin
            failures++; $display("FAIL midread_time got=%h exp=000000", {time_sec, time_min, time_hr});
        end
        bus_write(1'b0, 8'h10, 1'b0);
        bus_read(d, drv);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL midread_regs_cleared got=%h exp=00", d); end
    endtask

    initial begin
        reset_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; ad = 1'b0; tick_1hz = 1'b0;
        host_dato = 8'h00; host_drive = 1'b0;
        model_clear();
        test_reset();
        test_write_read();
        test_bcd_wrap();
        test_tick_collision();
        test_out_of_range();
        test_illegal();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
